alu_pipe: RTL
=============

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set operand/result width (legal 8..64, power of two).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operation request.
REQ-005 in_ready  output  1  block accepts request this cycle.
REQ-006 a, b  input  WIDTH each  operands.
REQ-007 f  input  4  operation code, per REQ-012.
REQ-008 out_valid  output  1  registered result available.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 y  output  WIDTH  registered result.
REQ-011 z, n, c, v  output  1 each  registered zero, negative, carry, overflow flags.

Function
REQ-012 Opcodes SHALL be:
- 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT signed.
- 0100 a AND NOT b; 0101 a OR NOT b; 0011 SLT computed as for 0111.
- 1000 SLL; 1001 SRL; 1010 SRA; 1011 SLTU; 1100 XOR; 1101 NOR; 1110 MUL; 1111 reserved.
REQ-013 For f[3]=0: f[2]=1 inverts b and sets adder carry-in to 1; f[1:0] selects AND/OR/adder/SLT.
REQ-014 Shift amount SHALL be b[log2(WIDTH)-1:0]; upper b bits are ignored.
REQ-015 SLT/SLTU SHALL return 1 or 0, zero-extended to WIDTH.
REQ-016 Opcode 1111 SHALL return y=0.
REQ-017 Transfer-in occurs when in_valid && in_ready; transfer-out occurs when out_valid && out_ready.
REQ-018 in_ready SHALL be high iff FSM is IDLE and (out_valid=0 or out_ready=1).
REQ-019 FSM states SHALL be IDLE and MUL.
REQ-020 Single-cycle ops: on transfer-in, y/flags SHALL be registered and out_valid=1 on the next edge (latency 1); back-to-back throughput of 1 per cycle.
REQ-021 out_valid SHALL stay 1 and y/flags SHALL stay constant until transfer-out.
REQ-022 On transfer-out with no transfer-in in the same cycle, out_valid SHALL clear on the next edge.
REQ-023 Simultaneous transfer-out and transfer-in SHALL load the new result, with out_valid remaining 1.
REQ-024 z SHALL be (y==0); n SHALL be y[WIDTH-1].
REQ-025 c SHALL be adder carry-out and v signed overflow, for ADD/SUB only; both SHALL be 0 for all other ops.
REQ-026 SUB carry SHALL follow a + ~b + 1 (c=1 means no borrow).
REQ-027 Inputs SHALL be sampled only at transfer-in; later input changes have no effect on that operation.

Reset
REQ-028 reset SHALL immediately force: FSM=IDLE, out_valid=0, y=0, z=0, n=0, c=0, v=0, multiply counter=0.
REQ-029 reset asserted mid-MUL SHALL abort the multiply; no result is delivered.
REQ-030 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-031 Macro ALU_PIPE_MUL_EN defined: opcode 1110 SHALL enter MUL and run an iterative shift-add unsigned multiply over exactly WIDTH cycles with in_ready=0.
REQ-032 With ALU_PIPE_MUL_EN, the multiply SHALL produce low WIDTH bits of a*b with out_valid=1 on edge WIDTH+1 after transfer-in, then return to IDLE.
REQ-033 With ALU_PIPE_MUL_EN, a multiply SHALL not start while an unconsumed result is held (enforced by REQ-018).
REQ-034 Macro ALU_PIPE_MUL_EN undefined: MUL state and multiplier logic SHALL be absent; 1110 SHALL behave as single-cycle y=0, z=1.

Verification (WIDTH=32 unless stated)
REQ-035 Bench SHALL cover: a=0x7FFFFFFF, b=1, f=0010 -> y=0x80000000, n=1, v=1, c=0, z=0, out_valid one cycle later.
REQ-036 Bench SHALL cover: a=5, b=5, f=0110 -> y=0, z=1, c=1, v=0; then a=0xFFFFFFFF, b=1, f=0111 -> y=1, and f=1011 -> y=0.
REQ-037 Bench SHALL cover: a=0x80000000, b=0x24, f=1010 -> y=0xF8000000 (shift 4); f=1001 -> y=0x08000000.
REQ-038 Bench SHALL cover backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and y stable; out_ready=1 -> one transfer-out per cycle with 4 back-to-back ops, no loss or duplication.
REQ-039 Bench SHALL cover, with ALU_PIPE_MUL_EN and WIDTH=8: a=13, b=11, f=1110 -> y=0x8F after 9 edges, in_ready=0 throughout.
REQ-040 Bench SHALL cover, with ALU_PIPE_MUL_EN and WIDTH=8: reset asserted at cycle 4 of MUL -> out_valid=0 and IDLE immediately; a new ADD 2+3 after reset returns y=5.

Source files
------------

// File: rtl/alu_pipe.sv
`timescale 1ns/1ps
// alu_pipe -- registered ALU with a valid/ready request side and a
// valid/ready result side.
//
// Configuration macro: ALU_PIPE_MUL_EN
//   defined   : opcode 1110 runs an iterative shift-add unsigned multiply
//               (WIDTH iterations plus one write-back cycle) in FSM state MUL.
//   undefined : no MUL state and no multiplier; 1110 returns y=0 in one cycle.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   request present            in_ready  request accepted this cycle
//   a, b       operands (WIDTH bits)      f         opcode (4 bits)
//   out_valid  registered result held     out_ready consumer takes the result
//   y          registered result          z,n,c,v   zero/negative/carry/overflow
//   state      FSM state (0 = IDLE, 1 = MUL), for debug and checkers
//
// Handshake: a transfer happens on a rising edge where valid && ready on the
// same side. A producer holding valid keeps its data stable until the
// transfer; in_ready never depends on in_valid, and out_valid/y/flags stay
// constant until out_ready is seen with out_valid.
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v,
    output logic [0:0]       state
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [0:0] IDLE = 1'b0;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] b_op;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic             slt;
    logic             sltu;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;

    always_comb begin
        // Low half of the opcode space: f[2] turns the adder into a
        // subtractor (invert b, carry-in 1) and also gives AND-NOT / OR-NOT.
        b_op  = f[2] ? ~b : b;
        cin   = f[2];
        sum   = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
        slt   = $signed(a) < $signed(b);
        sltu  = a < b;
        shamt = b[SHW-1:0];
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        if (!f[3]) begin
            case (f[1:0])
                2'b00: res = a & b_op;
                2'b01: res = a | b_op;
                2'b10: begin
                    // Only 0010 (ADD) and 0110 (SUB) land here, so carry and
                    // overflow are reported for exactly those two.
                    res   = sum[WIDTH-1:0];
                    res_c = sum[WIDTH];
                    res_v = (a[WIDTH-1] == b_op[WIDTH-1]) &&
                            (sum[WIDTH-1] != a[WIDTH-1]);
                end
                default: res = {{(WIDTH-1){1'b0}}, slt};
            endcase
        end else begin
            case (f[2:0])
                3'b000:  res = a << shamt;
                3'b001:  res = a >> shamt;
                3'b010:  res = $signed(a) >>> shamt;
                3'b011:  res = {{(WIDTH-1){1'b0}}, sltu};
                3'b100:  res = a ^ b;
                3'b101:  res = ~(a | b);
                default: res = '0;   // 1110 (handled by MUL when enabled), 1111
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic             xfer_in;
    logic             xfer_out;
    logic             start_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_y;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign xfer_in  = in_valid && in_ready;
    assign xfer_out = out_valid && out_ready;

`ifdef ALU_PIPE_MUL_EN
    // ------------------------------------------------------------------
    // Iterative shift-add multiplier: WIDTH add/shift steps, then one
    // cycle in which the accumulated product is written to the output.
    // ------------------------------------------------------------------
    localparam logic [0:0] MUL = 1'b1;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [SHW:0]     cnt;

    assign start_mul = xfer_in && (f == 4'b1110);
    assign mul_done  = (state == MUL) && (cnt == (SHW+1)'(WIDTH));
    assign mul_y     = acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_mul) begin
                        state  <= MUL;
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                default: begin
                    if (cnt == (SHW+1)'(WIDTH)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end
`else
    assign start_mul = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_y     = '0;
    assign state     = IDLE;
`endif

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            y         <= '0;
            z         <= 1'b0;
            n         <= 1'b0;
            c         <= 1'b0;
            v         <= 1'b0;
        end else if (xfer_in && !start_mul) begin
            // New single-cycle result; also covers accept-and-consume in
            // the same cycle, keeping out_valid high.
            out_valid <= 1'b1;
            y         <= res;
            z         <= (res == '0);
            n         <= res[WIDTH-1];
            c         <= res_c;
            v         <= res_v;
        end else if (mul_done) begin
            out_valid <= 1'b1;
            y         <= mul_y;
            z         <= (mul_y == '0);
            n         <= mul_y[WIDTH-1];
            c         <= 1'b0;
            v         <= 1'b0;
        end else if (xfer_out) begin
            // Also the path when a multiply starts while the previous
            // result is being consumed: nothing valid until the product.
            out_valid <= 1'b0;
        end
    end

endmodule
